mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline, sitting between the EX/MEM register and the write-back stage. It consumes the EX/MEM register's outputs and drives a data-memory request/ready handshake that tolerates variable memory latency. It stalls the upstream pipeline while an access is outstanding, resolves branches, and holds the MEM/WB pipeline register.

---
 rtl/rv_pipe_pkg.sv | 21 ++
 rtl/mem_wb.sv | 61 ++++++
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline memory stage.
//   mem_state_e      : handshake FSM state encoding
//   BUBBLE_*         : control values written into MEM/WB for a bubble
//   ALIGN_MASK       : required value of address bits [1:0] for a word access
//   is_misaligned()  : alignment test for a memory operation
package rv_pipe_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   localparam logic       BUBBLE_REGWRITE = 1'b0;
   localparam logic       BUBBLE_MEMTOREG = 1'b0;
   localparam logic [1:0] ALIGN_MASK      = 2'b00;

   function automatic logic is_misaligned(input logic mem_op, input logic [1:0] addr_lsb);
      return mem_op & (addr_lsb != ALIGN_MASK);
   endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register.
//   clk, rst_n      : clock, async active-low reset (all outputs clear)
//   i_bubble        : clear regwrite/memtoreg, hold all other fields (has priority)
//   i_load          : capture alu_result, register_rd and control bits
//   i_rdata_en      : together with i_load, also capture i_read_data
//   i_*             : next-stage values
//   o_*             : registered MEM/WB outputs
module mem_wb
   import rv_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_bubble,
   input  logic        i_load,
   input  logic        i_rdata_en,
   input  logic [31:0] i_read_data,
   input  logic [31:0] i_alu_result,
   input  logic [4:0]  i_register_rd,
   input  logic        i_memtoreg,
   input  logic        i_regwrite,
   output logic [31:0] o_read_data,
   output logic [31:0] o_alu_result,
   output logic [4:0]  o_register_rd,
   output logic        o_memtoreg,
   output logic        o_regwrite
);

   logic [31:0] r_read_data;
   logic [31:0] r_alu_result;
   logic [4:0]  r_register_rd;
   logic        r_memtoreg;
   logic        r_regwrite;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_read_data   <= '0;
         r_alu_result  <= '0;
         r_register_rd <= '0;
         r_memtoreg    <= 1'b0;
         r_regwrite    <= 1'b0;
      end else if (i_bubble) begin
         r_memtoreg    <= BUBBLE_MEMTOREG;
         r_regwrite    <= BUBBLE_REGWRITE;
      end else if (i_load) begin
         r_alu_result  <= i_alu_result;
         r_register_rd <= i_register_rd;
         r_memtoreg    <= i_memtoreg;
         r_regwrite    <= i_regwrite;
         if (i_rdata_en) begin
            r_read_data <= i_read_data;
         end
      end
   end

   assign o_read_data   = r_read_data;
   assign o_alu_result  = r_alu_result;
   assign o_register_rd = r_register_rd;
   assign o_memtoreg    = r_memtoreg;
   assign o_regwrite    = r_regwrite;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data-memory request/ready handshake with a bounded
// wait, upstream stall generation, branch resolution and the MEM/WB register.
//   clk, rst_n            : clock, async active-low reset
//   ex_mem_*              : EX/MEM register outputs (held by the upstream while mem_stall=1)
//   zero_flag_ex_mem      : ALU zero flag for branch resolution
//   dmem_*                : data-memory request/ready interface
//   mem_stall             : freezes PC, IF/ID, ID/EX and EX/MEM
//   pcsrc                 : branch taken
//   mem_err               : sticky misaligned/timeout flag, cleared only by reset
//   mem_wb_*              : MEM/WB register outputs
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no access outstanding; aligned mem op issues a request here
// WAIT    | request held, counting cycles until dmem_ready or timeout
module mem_stage
   import rv_pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16   // 2..255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] ex_mem_output_data_2,
   input  logic [4:0]  ex_mem_register_rd,
   input  logic        ex_mem_memtoreg,
   input  logic        ex_mem_regwrite,
   input  logic        ex_mem_memread,
   input  logic        ex_mem_memwrite,
   input  logic        ex_mem_branch,
   input  logic        zero_flag_ex_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        mem_stall,
   output logic        pcsrc,
   output logic        mem_err,
   output logic [31:0] mem_wb_read_data,
   output logic [31:0] mem_wb_alu_result,
   output logic [4:0]  mem_wb_register_rd,
   output logic        mem_wb_memtoreg,
   output logic        mem_wb_regwrite
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   mem_state_e r_state;
   mem_state_e w_state_nxt;
   logic [7:0] r_count;
   logic [7:0] w_count_nxt;
   logic       r_err;

   logic w_mem_op;
   logic w_misaligned;
   logic w_last_wait;
   logic w_req;
   logic w_load;
   logic w_bubble;
   logic w_err_set;

   assign w_mem_op     = ex_mem_memread | ex_mem_memwrite;
   assign w_misaligned = is_misaligned(w_mem_op, ex_mem_alu_result[1:0]);
   assign w_last_wait  = (r_state == ST_WAIT) && (r_count == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_req       = 1'b0;
      w_load      = 1'b0;
      w_bubble    = 1'b0;
      w_err_set   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_req = w_mem_op & ~w_misaligned;
            if (w_misaligned) begin
               w_bubble  = 1'b1;
               w_err_set = 1'b1;
            end else if (!w_mem_op || dmem_ready) begin
               w_load = 1'b1;
            end else begin
               // first stalled cycle counts as wait cycle 0
               w_bubble    = 1'b1;
               w_state_nxt = ST_WAIT;
               w_count_nxt = 8'd1;
            end
         end
         ST_WAIT: begin
            w_req = 1'b1;
            if (dmem_ready) begin
               w_load      = 1'b1;
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
            end else if (w_last_wait) begin
               w_bubble    = 1'b1;
               w_err_set   = 1'b1;
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
            end else begin
               w_bubble    = 1'b1;
               w_count_nxt = r_count + 8'd1;
            end
         end
      endcase
   end

   // Gated by rst_n so request and stall drop during reset without a clock edge.
   assign dmem_req   = rst_n & w_req;
   assign dmem_we    = ex_mem_memwrite;
   assign dmem_addr  = ex_mem_alu_result;
   assign dmem_wdata = ex_mem_output_data_2;
   assign mem_stall  = dmem_req & ~dmem_ready & ~w_last_wait;
   assign pcsrc      = ex_mem_branch & zero_flag_ex_mem;
   assign mem_err    = r_err;

   mem_wb u_mem_wb (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_bubble      (w_bubble),
      .i_load        (w_load),
      .i_rdata_en    (w_mem_op & ~ex_mem_memwrite),
      .i_read_data   (dmem_rdata),
      .i_alu_result  (ex_mem_alu_result),
      .i_register_rd (ex_mem_register_rd),
      .i_memtoreg    (ex_mem_memtoreg),
      .i_regwrite    (ex_mem_regwrite),
      .o_read_data   (mem_wb_read_data),
      .o_alu_result  (mem_wb_alu_result),
      .o_register_rd (mem_wb_register_rd),
      .o_memtoreg    (mem_wb_memtoreg),
      .o_regwrite    (mem_wb_regwrite)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage (TIMEOUT=4): directed scenarios followed by random
// instructions, each checked against an instruction-level model.
module tb_mem_stage;

   localparam int T = 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] ex_mem_alu_result;
   logic [31:0] ex_mem_output_data_2;
   logic [4:0]  ex_mem_register_rd;
   logic        ex_mem_memtoreg;
   logic        ex_mem_regwrite;
   logic        ex_mem_memread;
   logic        ex_mem_memwrite;
   logic        ex_mem_branch;
   logic        zero_flag_ex_mem;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        mem_stall;
   logic        pcsrc;
   logic        mem_err;
   logic [31:0] mem_wb_read_data;
   logic [31:0] mem_wb_alu_result;
   logic [4:0]  mem_wb_register_rd;
   logic        mem_wb_memtoreg;
   logic        mem_wb_regwrite;

   mem_stage #(.TIMEOUT(T)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .ex_mem_alu_result    (ex_mem_alu_result),
      .ex_mem_output_data_2 (ex_mem_output_data_2),
      .ex_mem_register_rd   (ex_mem_register_rd),
      .ex_mem_memtoreg      (ex_mem_memtoreg),
      .ex_mem_regwrite      (ex_mem_regwrite),
      .ex_mem_memread       (ex_mem_memread),
      .ex_mem_memwrite      (ex_mem_memwrite),
      .ex_mem_branch        (ex_mem_branch),
      .zero_flag_ex_mem     (zero_flag_ex_mem),
      .dmem_req             (dmem_req),
      .dmem_we              (dmem_we),
      .dmem_addr            (dmem_addr),
      .dmem_wdata           (dmem_wdata),
      .dmem_rdata           (dmem_rdata),
      .dmem_ready           (dmem_ready),
      .mem_stall            (mem_stall),
      .pcsrc                (pcsrc),
      .mem_err              (mem_err),
      .mem_wb_read_data     (mem_wb_read_data),
      .mem_wb_alu_result    (mem_wb_alu_result),
      .mem_wb_register_rd   (mem_wb_register_rd),
      .mem_wb_memtoreg      (mem_wb_memtoreg),
      .mem_wb_regwrite      (mem_wb_regwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // model of MEM/WB contents and the error flag
   logic [31:0] m_alu, m_rdata;
   logic [4:0]  m_rd;
   logic        m_m2r, m_rw, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_alu = '0; m_rdata = '0; m_rd = '0; m_m2r = 1'b0; m_rw = 1'b0; m_err = 1'b0;
   endtask

   task automatic chk_wb(input string tag);
      chk({tag, "_rdata"}, mem_wb_read_data, m_rdata);
      chk({tag, "_alu"}, mem_wb_alu_result, m_alu);
      chk({tag, "_rd"}, 32'(mem_wb_register_rd), 32'(m_rd));
      chk({tag, "_m2r"}, 32'(mem_wb_memtoreg), 32'(m_m2r));
      chk({tag, "_rw"}, 32'(mem_wb_regwrite), 32'(m_rw));
      chk({tag, "_err"}, 32'(mem_err), 32'(m_err));
   endtask

   // Called at posedge+1; reset pulse without a clock edge, then release.
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_clear();
      chk({tag, "_req"}, 32'(dmem_req), 32'd0);
      chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
      chk_wb(tag);
      #1;
      rst_n = 1'b1;
   endtask

   // One instruction in EX/MEM. lat = request cycle (0-based) on which the
   // memory first answers ready. Called and returns at posedge+1.
   task automatic run_instr(input string tag, input logic rd_, input logic wr_,
                            input logic br_, input logic zf_,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [4:0] rd,
                            input logic m2r, input logic rw, input int lat);
      logic mem_op, mis, issue, done_ok;
      int   n_cyc;
      ex_mem_memread       = rd_;
      ex_mem_memwrite      = wr_;
      ex_mem_branch        = br_;
      zero_flag_ex_mem     = zf_;
      ex_mem_alu_result    = addr;
      ex_mem_output_data_2 = wdata;
      ex_mem_register_rd   = rd;
      ex_mem_memtoreg      = m2r;
      ex_mem_regwrite      = rw;
      mem_op  = rd_ | wr_;
      mis     = mem_op && (addr[1:0] != 2'b00);
      issue   = mem_op && !mis;
      done_ok = issue && (lat <= T - 1);
      n_cyc   = !issue ? 1 : (done_ok ? lat + 1 : T);
      for (int c = 0; c < n_cyc; c++) begin
         if (issue) begin
            dmem_ready = (c >= lat);
            dmem_rdata = (c >= lat) ? rdata : $urandom;
         end else begin
            dmem_ready = 1'($urandom);
            dmem_rdata = $urandom;
         end
         @(negedge clk);
         chk({tag, "_req"}, 32'(dmem_req), 32'(issue));
         chk({tag, "_stall"}, 32'(mem_stall), 32'(issue && (c < n_cyc - 1)));
         chk({tag, "_pcsrc"}, 32'(pcsrc), 32'(br_ & zf_));
         if (issue) begin
            chk({tag, "_we"}, 32'(dmem_we), 32'(wr_));
            chk({tag, "_addr"}, dmem_addr, addr);
            if (wr_) chk({tag, "_wdata"}, dmem_wdata, wdata);
         end
         @(posedge clk);
         #1;
         if (issue && (c < n_cyc - 1)) begin
            m_rw  = 1'b0;
            m_m2r = 1'b0;
            chk({tag, "_bub_rw"}, 32'(mem_wb_regwrite), 32'd0);
            chk({tag, "_bub_m2r"}, 32'(mem_wb_memtoreg), 32'd0);
            chk({tag, "_bub_alu"}, mem_wb_alu_result, m_alu);
         end
      end
      if (!mem_op || done_ok) begin
         m_alu = addr; m_rd = rd; m_m2r = m2r; m_rw = rw;
         if (done_ok && !wr_) m_rdata = rdata;
      end else begin
         m_rw = 1'b0; m_m2r = 1'b0; m_err = 1'b1;
      end
      chk_wb(tag);
   endtask

   initial begin
      int kind;
      logic [31:0] a;
      rst_n = 1'b0;
      ex_mem_alu_result = '0; ex_mem_output_data_2 = '0; ex_mem_register_rd = '0;
      ex_mem_memtoreg = 1'b0; ex_mem_regwrite = 1'b0; ex_mem_memread = 1'b1;
      ex_mem_memwrite = 1'b0; ex_mem_branch = 1'b0; zero_flag_ex_mem = 1'b0;
      dmem_rdata = '0; dmem_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk_wb("rst");
      rst_n = 1'b1;

      run_instr("ld0w", 1, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1, 1, 0);
      run_instr("st3w", 0, 1, 0, 0, 32'h40, 32'h1234, 32'h0, 5'd0, 0, 0, 3);
      run_instr("ldto", 1, 0, 0, 0, 32'h80, 32'h0, 32'hCAFE0000, 5'd7, 1, 1, 1000);
      run_instr("alu", 0, 0, 0, 0, 32'h55AA, 32'h0, 32'h0, 5'd9, 0, 1, 0);
      run_instr("brt", 0, 0, 1, 1, 32'h8, 32'h0, 32'h0, 5'd0, 0, 0, 0);
      run_instr("brn", 0, 0, 1, 0, 32'h8, 32'h0, 32'h0, 5'd0, 0, 0, 0);
      run_instr("ldst", 1, 1, 0, 0, 32'h200, 32'h77, 32'h11, 5'd3, 0, 0, 1);

      pulse_reset("rst2");
      run_instr("mis", 1, 0, 0, 0, 32'h102, 32'h0, 32'h1111, 5'd4, 1, 1, 0);
      run_instr("ldpost", 1, 0, 0, 0, 32'h104, 32'h0, 32'h2222, 5'd6, 1, 1, 2);

      // reset during the second wait cycle of a never-ready load
      ex_mem_memread = 1'b1; ex_mem_memwrite = 1'b0; ex_mem_alu_result = 32'h300;
      dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midw_stall_pre", 32'(mem_stall), 32'd1);
      pulse_reset("midw");
      run_instr("ldrec", 1, 0, 0, 0, 32'h304, 32'h0, 32'hA5A5A5A5, 5'd8, 1, 1, 1);

      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 11);
         a = {$urandom_range(0, 32'h3FFF), 2'b00};
         case (kind)
            0, 1, 2: run_instr("rld", 1, 0, 0, 0, a, $urandom, $urandom, 5'($urandom), 1, 1, $urandom_range(0, 5));
            3, 4:    run_instr("rst", 0, 1, 0, 0, a, $urandom, $urandom, 5'($urandom), 0, 0, $urandom_range(0, 5));
            5:       run_instr("rboth", 1, 1, 0, 0, a, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5));
            6, 7, 8: run_instr("ralu", 0, 0, 0, 0, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 0);
            9, 10:   run_instr("rbr", 0, 0, 1, 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 0, 0, 0);
            default: run_instr("rmis", 1'($urandom), 1, 0, 0, a | 32'($urandom_range(1, 3)), $urandom, $urandom, 5'($urandom), 1, 1, 0);
         endcase
         if (i == 30) pulse_reset("rrst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
